// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch (IF) stage.
//   XLEN_DEFAULT  : default datapath / PC width
//   NOP_INSTR     : instruction presented to decode when nothing is valid
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : one fetched instruction {pc, instr}
//   fetch_tag_t   : per-request bookkeeping {epoch, pc}, kept in request order
package fetch_pkg;

   localparam int          XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INSTR    = 32'h00000013;
   localparam int          PC_STEP      = 4;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [31:0]             instr;
   } fetch_entry_t;

   typedef struct packed {
      logic                    epoch;
      logic [XLEN_DEFAULT-1:0] pc;
   } fetch_tag_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO with a flush input.
// Used both as the instruction queue and as the in-order request tag FIFO.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   flush       : empties the FIFO at the next edge (wins over push/pop)
//   push, wdata : write an entry (ignored when full unless popping too)
//   pop         : discard the head entry (ignored when empty)
//   rdata       : head entry, valid when count != 0
//   count       : number of stored entries
module fetch_queue #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           push,
   input  logic [W-1:0]                   wdata,
   input  logic                           pop,
   output logic [W-1:0]                   rdata,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          empty;
   logic          full;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage is data only; the pointers decide what is meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Owns the PC, issues instruction-memory reads, buffers
// returned words and presents the head word to decode.
// Optional feature macro: FETCH_PERF_EN (adds perf_* counter outputs).
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   imem_req_valid/ready/addr        : read request channel (word aligned)
//   imem_resp_valid/data             : read data, returned in request order
//   redirect_valid/pc                : EX redirect, flushes younger fetches
//   id_ready                         : decode accepts head (low = stall)
//   if_id_valid/pc/instruction       : head instruction (NOP when invalid)
//   perf_fetched/stall_cycles/flushed: saturating counters (FETCH_PERF_EN)
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int             XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int             QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instruction
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall_cycles,
   output logic [31:0]     perf_flushed
`endif
);

   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   logic [XLEN-1:0] pc;
   logic            epoch;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   q_count;
   logic [CW:0]     in_flight;
   fetch_entry_t    q_wdata;
   fetch_entry_t    q_rdata;
   fetch_tag_t      t_wdata;
   fetch_tag_t      t_rdata;
   logic            q_empty;
   logic            if_pop;
   logic            q_pop;
   logic            req_fire;
   logic            resp_accept;
   logic            tag_match;
   logic            resp_keep;

   assign q_empty = (q_count == '0);
   assign if_pop  = if_id_valid && id_ready;
   assign q_pop   = if_pop && !redirect_valid;

   // The tag FIFO count is the number of outstanding reads. A head that leaves
   // this cycle frees its slot, which keeps one instruction per cycle flowing
   // with a 1-cycle memory.
   assign in_flight      = {1'b0, outstanding} + {1'b0, q_count} - (CW + 1)'(if_pop);
   assign imem_req_valid = !reset && !redirect_valid && (in_flight < (CW + 1)'(QDEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses with nothing outstanding are protocol errors and are ignored.
   assign resp_accept = imem_resp_valid && (outstanding != '0);
   assign tag_match   = (t_rdata.epoch == epoch);
   assign resp_keep   = resp_accept && tag_match && !redirect_valid;

   assign t_wdata = '{epoch: epoch, pc: pc};
   assign q_wdata = '{pc: t_rdata.pc, instr: imem_resp_data};

   fetch_queue #(.W($bits(fetch_tag_t)), .DEPTH(QDEPTH)) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (1'b0),
      .push  (req_fire),
      .wdata (t_wdata),
      .pop   (resp_accept),
      .rdata (t_rdata),
      .count (outstanding)
   );

   fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_inst_queue (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (resp_keep),
      .wdata (q_wdata),
      .pop   (q_pop),
      .rdata (q_rdata),
      .count (q_count)
   );

   assign if_id_valid       = !q_empty;
   assign if_id_pc          = q_empty ? '0 : q_rdata.pc;
   assign if_id_instruction = q_empty ? NOP_INSTR : q_rdata.instr;

   // Redirect toggles the epoch so every read already in flight comes back
   // stale; outstanding is left alone so those reads drain naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_PC & ALIGN_MASK;
         epoch <= 1'b0;
      end else if (redirect_valid) begin
         pc    <= redirect_pc & ALIGN_MASK;
         epoch <= ~epoch;
      end else if (req_fire) begin
         pc    <= pc + XLEN'(PC_STEP);
      end
   end

`ifdef FETCH_PERF_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   logic [31:0] flush_inc;

   assign flush_inc = redirect_valid ? (32'(q_count) + 32'(resp_accept))
                                     : 32'(resp_accept && !tag_match);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched      <= '0;
         perf_stall_cycles <= '0;
         perf_flushed      <= '0;
      end else begin
         perf_fetched      <= sat_add(perf_fetched, 32'(resp_keep));
         perf_stall_cycles <= sat_add(perf_stall_cycles, 32'(if_id_valid && !id_ready));
         perf_flushed      <= sat_add(perf_flushed, flush_inc);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Directed tests push the
// expected {pc, instr} sequence; a monitor pops and compares every instruction
// decode accepts. A memory model with programmable latency, request budget and
// ready pattern answers the fetch requests.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instruction;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flushed;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_req_addr     (imem_req_addr),
      .imem_resp_valid   (imem_resp_valid),
      .imem_resp_data    (imem_resp_data),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .id_ready          (id_ready),
      .if_id_valid       (if_id_valid),
      .if_id_pc          (if_id_pc),
      .if_id_instruction (if_id_instruction)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flushed      (perf_flushed)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   exp_t  sb[$];
   mreq_t mq[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    lat      = 1;
   int    budget   = 0;
   logic  base_ready = 1'b1;
   logic  cap_en   = 1'b0;
   int    cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h00100093;   // addi x1,x0,1
         32'h4:   return 32'h00200113;   // addi x2,x0,2
         32'h8:   return 32'h00300193;   // addi x3,x0,3
         32'hC:   return 32'h00400213;   // addi x4,x0,4
         default: return 32'hA000_0000 | a;
      endcase
   endfunction

   task automatic exp_push(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      sb.push_back(e);
   endtask

   // Memory model: a request accepted at an edge is answered LAT cycles later.
   initial begin
      logic        fire;
      logic [31:0] faddr;
      mreq_t       r;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         fire  = imem_req_valid && imem_req_ready;
         faddr = imem_req_addr;
         @(posedge clk);
         cyc++;
         if (imem_resp_valid) void'(mq.pop_front());
         if (fire) begin
            r.addr = faddr;
            r.due  = cyc + lat - 1;
            mq.push_back(r);
            budget--;
            if (cap_en) chk("outstanding_cap", 32'(mq.size() <= 2), 32'd1);
         end
         #2;
         imem_req_ready = base_ready && (budget > 0);
         if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memword(mq[0].addr);
         end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
         end
      end
   end

   // Monitor: every instruction decode accepts must be the next expected one.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && if_id_valid && id_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_instr_pc", if_id_pc, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("sb_pc", if_id_pc, e.pc);
               chk("sb_instr", if_id_instruction, e.instr);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #3;
   endtask

   task automatic drain();
      int n;
      n = 0;
      base_ready = 1'b1;
      while ((sb.size() > 0 || mq.size() > 0) && n < 200) begin
         step();
         n++;
      end
      chk("drain_done", 32'(sb.size() == 0 && mq.size() == 0), 32'd1);
      sb.delete();
      step();
   endtask

   task automatic do_reset(input int lat_v);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;
      budget         = 0;
      base_ready     = 1'b1;
      cap_en         = 1'b0;
      lat            = lat_v;
      step();
      step();
      look();
      chk("rst_if_id_valid", 32'(if_id_valid), 32'd0);
      chk("rst_if_id_pc", if_id_pc, 32'h0);
      chk("rst_instr_nop", if_id_instruction, 32'h00000013);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;

      // Test 1: streaming fetch, one instruction per cycle.
      do_reset(1);
      budget = 4;
      exp_push(32'h0, 32'h00100093);
      exp_push(32'h4, 32'h00200113);
      exp_push(32'h8, 32'h00300193);
      exp_push(32'hC, 32'h00400213);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step();
         look();
         if (k < 4) begin
            chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
            chk("t1_req_addr", imem_req_addr, 32'(4 * k));
         end
         if (k >= 2) begin
            chk("t1_if_id_valid", 32'(if_id_valid), 32'd1);
            chk("t1_if_id_pc", if_id_pc, 32'(4 * (k - 2)));
         end
      end
      drain();

      // Test 2: decode stall with two words buffered.
      do_reset(1);
      budget = 5;
      exp_push(32'h0, 32'h00100093);
      exp_push(32'h4, 32'h00200113);
      exp_push(32'h8, 32'h00300193);
      exp_push(32'hC, 32'h00400213);
      exp_push(32'h10, 32'hA000_0010);
      for (int k = 1; k < 8; k++) begin
         step();
         if (k == 4) id_ready = 1'b0;
         if (k == 7) id_ready = 1'b1;
         look();
         if (k >= 4 && k <= 6) begin
            chk("t2_hold_valid", 32'(if_id_valid), 32'd1);
            chk("t2_hold_pc", if_id_pc, 32'h8);
            chk("t2_hold_instr", if_id_instruction, 32'h00300193);
            chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
         end
      end
      drain();
`ifdef FETCH_PERF_EN
      chk("t2_perf_stall", perf_stall_cycles, 32'd3);
      chk("t2_perf_fetched", perf_fetched, 32'd5);
`endif

      // Test 3: redirect with two reads in flight (3-cycle memory).
      do_reset(3);
      budget = 2;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h44;
      look();
      chk("t3_req_valid_redirect", 32'(imem_req_valid), 32'd0);
      step();
      redirect_valid = 1'b0;
      budget = 2;
      exp_push(32'h44, 32'hA000_0044);
      exp_push(32'h48, 32'hA000_0048);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         look();
         chk("t3_stale_dropped", 32'(if_id_valid), 32'd0);
      end
      drain();
`ifdef FETCH_PERF_EN
      chk("t3_perf_flushed", perf_flushed, 32'd2);
      chk("t3_perf_fetched", perf_fetched, 32'd2);
`endif

      // Test 4: unaligned target and back-to-back redirects.
      do_reset(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4B;
      look();
      chk("t4_req_valid_redirect", 32'(imem_req_valid), 32'd0);
      step();
      redirect_pc = 32'h40;
      look();
      chk("t4_aligned_addr", imem_req_addr, 32'h48);
      step();
      redirect_pc = 32'h50;
      look();
      chk("t4_second_target", imem_req_addr, 32'h40);
      step();
      redirect_valid = 1'b0;
      budget = 2;
      look();
      chk("t4_last_wins_addr", imem_req_addr, 32'h50);
      chk("t4_req_valid_after", 32'(imem_req_valid), 32'd1);
      exp_push(32'h50, 32'hA000_0050);
      exp_push(32'h54, 32'hA000_0054);
      drain();

      // Test 5: reset mid-operation with a read in flight and a word queued.
      do_reset(3);
      id_ready = 1'b0;
      budget = 1;
      for (int k = 1; k <= 4; k++) step();
      budget = 1;
      look();
      chk("t5_pre_valid", 32'(if_id_valid), 32'd1);
      chk("t5_pre_pc", if_id_pc, 32'h0);
      step();
      reset = 1'b1;
      budget = 0;
      step();
      look();
      chk("t5_rst_valid", 32'(if_id_valid), 32'd0);
      chk("t5_rst_instr", if_id_instruction, 32'h00000013);
      chk("t5_rst_pc", if_id_pc, 32'h0);
      chk("t5_rst_req_valid", 32'(imem_req_valid), 32'd0);
      step();
      reset = 1'b0;
      step();
      look();
      chk("t5_late_dropped", 32'(if_id_valid), 32'd0);
      chk("t5_restart_addr", imem_req_addr, 32'h0);
      id_ready = 1'b1;
      budget = 1;
      exp_push(32'h0, 32'h00100093);
      drain();

      // Test 6: 3-cycle memory with a toggling ready.
      do_reset(3);
      cap_en = 1'b1;
      budget = 6;
      for (int k = 0; k < 6; k++) exp_push(32'(4 * k), memword(32'(4 * k)));
      for (int k = 0; k < 30; k++) begin
         base_ready = (k % 3 != 1);
         step();
      end
      drain();
      cap_en = 1'b0;
`ifdef FETCH_PERF_EN
      chk("t6_perf_flushed", perf_flushed, 32'd0);
      chk("t6_perf_fetched", perf_fetched, 32'd6);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
